add_pipe_arbiter: RTL and testbench
===================================

Name: add_pipe_arbiter

Overview:
Shares one pipelined adder instance (valid-gated, no stall input, fixed latency) among NUM_REQ requesters.
- Round-robin arbitration admits at most one operand pair per cycle into the adder.
- An ID tag travels in a shift register alongside each in-flight operation.
- Results land in a credit-protected result FIFO with a ready/valid response port, so the adder never has to stall.
- Sits in front of the generated pipeline wrapper; its pipe_* ports connect directly to the adder's operand, valid, result and out_valid ports.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand/result width
LATENCY, 2, adder cycles from pipe_valid to pipe_out_valid (>=1)
FIFO_DEPTH, 4, result FIFO entries (>=1; full throughput needs >= LATENCY+2)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_a  in  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  operand b, same packing
pipe_valid  out  1  issue strobe to adder in_valid
pipe_a  out  WIDTH  operand a to adder
pipe_b  out  WIDTH  operand b to adder
pipe_out_valid  in  1  adder out_valid
pipe_c  in  WIDTH  adder result
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_data  out  WIDTH  sum
resp_id  out  clog2(NUM_REQ)  requester index of resp_data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and is shared with the adder.
- Reset values:
  - All outputs 0; resp_valid=0.
  - RR pointer = 0; credits = FIFO_DEPTH.
  - FIFO empty; tag shift register cleared.
- Issue condition: issue = |req_valid && credits!=0.
- Grant:
  - Winner is the first i with req_valid[i], scanning from the pointer upward with wrap.
  - req_ready[winner]=1 only when issue; all other bits 0.
  - req_ready is combinational from req_valid and credits.
- Pointer update: on issue, pointer <= (winner+1) mod NUM_REQ; otherwise unchanged.
- Adder drive:
  - pipe_valid = issue.
  - pipe_a/pipe_b = winner's operands when issue, else 0 (combinational).
- Tag pipe:
  - LATENCY-deep shift of {valid, id}, advancing every cycle.
  - Tag at stage LATENCY aligns with pipe_out_valid.
  - A tag-valid / pipe_out_valid mismatch is a fatal simulation assertion.
- FIFO:
  - First-word-fall-through.
  - Pushes {pipe_c, tag id} when pipe_out_valid.
  - Pops when resp_valid && resp_ready; resp_valid = !empty.
  - Simultaneous push and pop are legal at any occupancy.
  - Pointers wrap modulo FIFO_DEPTH.
- Credits:
  - Counter width clog2(FIFO_DEPTH+1).
  - Decrement on issue, increment on pop, unchanged on both.
  - Invariant: credits + in-flight + occupancy == FIFO_DEPTH; overflow is therefore impossible.
- Latency:
  - Request accepted in cycle T gives pipe_out_valid in T+LATENCY and resp_valid in T+LATENCY+1 (empty FIFO).
  - Default latency is 3 cycles.
- Arithmetic: the sum is the adder's modulo-2^WIDTH result, passed through untouched.
- Zero credits: with credits==0, all req_ready are 0. A pop in the same cycle does not enable issue until the next cycle (credits is a registered value).
- Reset mid-operation: in-flight tags and FIFO contents are discarded and credits restored. The adder's valid registers clear on the same rst, so no stale result is pushed.

Optional Feature:
ADD_PIPE_ARB_STATS_EN:
- When defined, adds output ports issue_count[31:0] and credit_stall_count[31:0].
  - issue_count increments on every issue.
  - credit_stall_count increments on cycles with |req_valid && credits==0.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request, isolated: req 2 with a=5, b=7 in cycle 0. Expect req_ready=4'b0100 in cycle 0, pipe_valid=1 in cycle 0, resp_valid=1 with data=12 and id=2 in cycle 3.
- Full contention: all four requesters valid every cycle, resp_ready=1. Expect grants 0,1,2,3,0,...; then drop req 1 and expect order 2,3,0,2.
- Wrap-around arithmetic: a=0xFFFFFFFF, b=1 gives resp_data=0; a=0x80000000, b=0x80000000 gives 0.
- Backpressure: all requesters valid, resp_ready=0.
  - Exactly 4 issues occur, then req_ready=0.
  - The FIFO fills to 4 with no loss.
  - Raising resp_ready for 1 cycle yields one new issue the following cycle.
  - Responses arrive in issue order with correct ids.
- Reset mid-flight: issue 2 ops, assert rst 1 cycle in the next cycle. Expect no response ever, credits=4, pointer=0, and the next request served from requester 0 first.
- Stats (with ADD_PIPE_ARB_STATS_EN): backpressure scenario running 10 cycles. Expect issue_count=4, credit_stall_count=6.

Source files
------------

// File: rtl/add_pipe_arbiter_if.sv
// Request, adder-side and response signals of add_pipe_arbiter.
// slave is the arbiter's view; master is the requester/adder/consumer side.
interface add_pipe_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     pipe_valid;
    logic [WIDTH-1:0]         pipe_a;
    logic [WIDTH-1:0]         pipe_b;
    logic                     pipe_out_valid;
    logic [WIDTH-1:0]         pipe_c;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic [IDW-1:0]           resp_id;

    modport slave (
        input  req_valid, req_a, req_b, pipe_out_valid, pipe_c, resp_ready,
        output req_ready, pipe_valid, pipe_a, pipe_b, resp_valid, resp_data, resp_id
    );

    modport master (
        output req_valid, req_a, req_b, pipe_out_valid, pipe_c, resp_ready,
        input  req_ready, pipe_valid, pipe_a, pipe_b, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/add_pipe_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined adder with a credit-protected result FIFO.
// Optional ADD_PIPE_ARB_STATS_EN adds saturating issue / credit-stall counters.
module add_pipe_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    add_pipe_arbiter_if.slave   bus
`ifdef ADD_PIPE_ARB_STATS_EN
    ,
    output logic [31:0]         issue_count,
    output logic [31:0]         credit_stall_count
`endif
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [CW-1:0]    credits;
    logic             issue;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [LATENCY:1] tag_vld;
    logic [IDW-1:0]   tag_id [1:LATENCY];
    logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [IDW-1:0]   mem_id [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
            b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
        end
    end

    // Scan from the far end back toward ptr so the closest valid requester is the last writer.
    always_comb begin
        winner = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[rr_idx(ptr, k)]) winner = rr_idx(ptr, k);
        end
    end

    assign issue = (|bus.req_valid) && (credits != '0);

    always_comb begin
        bus.req_ready = '0;
        if (issue) bus.req_ready[winner] = 1'b1;
    end

    assign bus.pipe_valid = issue;
    assign bus.pipe_a     = issue ? a_arr[winner] : '0;
    assign bus.pipe_b     = issue ? b_arr[winner] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Tag stage k holds the op issued k cycles ago; stage LATENCY meets pipe_out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int k = 1; k <= LATENCY; k++) tag_id[k] <= '0;
        end else begin
            tag_vld[1] <= issue;
            tag_id[1]  <= winner;
            for (int k = 2; k <= LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            assert (tag_vld[LATENCY] == bus.pipe_out_valid)
                else $fatal(1, "add_pipe_arbiter: tag valid and pipe_out_valid disagree");
        end
    end

    assign push           = bus.pipe_out_valid;
    assign bus.resp_valid = (count != '0);
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign bus.resp_data  = bus.resp_valid ? mem_data[rd_ptr] : '0;
    assign bus.resp_id    = bus.resp_valid ? mem_id[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= bus.pipe_c;
            mem_id[wr_ptr]   <= tag_id[LATENCY];
        end
    end

    // Credits reserve a FIFO slot at issue time, so a push can never find the FIFO full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            credits <= CW'(FIFO_DEPTH);
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({issue, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

`ifdef ADD_PIPE_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_count        <= '0;
            credit_stall_count <= '0;
        end else begin
            if (issue) issue_count <= sat_inc(issue_count);
            if ((|bus.req_valid) && (credits == '0))
                credit_stall_count <= sat_inc(credit_stall_count);
        end
    end
`endif
endmodule

// File: tb/tb_add_pipe_arbiter.sv
// Randomized and directed bench for add_pipe_arbiter with an in-bench adder and scoreboard.
module tb_add_pipe_arbiter;
    localparam int NR  = 4;
    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int FD  = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic [1:0]   id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add_pipe_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

`ifdef ADD_PIPE_ARB_STATS_EN
    logic [31:0] issue_count;
    logic [31:0] credit_stall_count;
`endif

    add_pipe_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ADD_PIPE_ARB_STATS_EN
        ,
        .issue_count(issue_count),
        .credit_stall_count(credit_stall_count)
`endif
    );

    // Valid-gated adder with fixed latency, sharing rst with the arbiter
    logic [LAT:1] add_v;
    logic [W-1:0] add_s [1:LAT];
    always @(posedge clk) begin
        if (rst) begin
            add_v <= '0;
        end else begin
            add_v[1] <= bus.pipe_valid;
            add_s[1] <= bus.pipe_a + bus.pipe_b;
            for (int k = 2; k <= LAT; k++) begin
                add_v[k] <= add_v[k-1];
                add_s[k] <= add_s[k-1];
            end
        end
    end
    assign bus.pipe_out_valid = add_v[LAT];
    assign bus.pipe_c         = add_s[LAT];

    int n_chk = 0;
    int n_err = 0;
    int ptr_m = 0;
    int outstanding = 0;
    int issues_m = 0;
    int stalls_m = 0;
    exp_t q[$];
    int grants[$];
    logic [W-1:0] a_in [NR];
    logic [W-1:0] b_in [NR];
    logic [31:0] last_ic = '0;
    logic [31:0] last_sc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            a_in[i] = $urandom;
            b_in[i] = $urandom;
        end
    endtask

    // One clock cycle: apply inputs, check the grant against the round-robin/credit model.
    task automatic drive(input logic [NR-1:0] v, input logic rr);
        int credits_m;
        int win;
        int idx;
        logic exp_issue;
        logic [NR-1:0] er;
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid  = v;
        bus.resp_ready = rr;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*W +: W] = a_in[i];
            bus.req_b[i*W +: W] = b_in[i];
        end
        #1;
`ifdef ADD_PIPE_ARB_STATS_EN
        last_ic = issue_count;
        last_sc = credit_stall_count;
        chk("issue_count", issue_count, issues_m);
        chk("credit_stall_count", credit_stall_count, stalls_m);
`endif
        credits_m = FD - outstanding;
        exp_issue = (v != '0) && (credits_m != 0);
        win = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (ptr_m + k) % NR;
            if (win < 0 && v[idx]) win = idx;
        end
        er = '0;
        if (exp_issue) er[win] = 1'b1;
        chk("req_ready", bus.req_ready, er);
        chk("pipe_valid", bus.pipe_valid, exp_issue);
        chk("pipe_a", bus.pipe_a, exp_issue ? a_in[win] : '0);
        chk("pipe_b", bus.pipe_b, exp_issue ? b_in[win] : '0);
        if (v != '0 && credits_m == 0) stalls_m++;
        if (exp_issue) begin
            e.sum = a_in[win] + b_in[win];
            e.id  = 2'(win);
            q.push_back(e);
            outstanding++;
            ptr_m = (win + 1) % NR;
            grants.push_back(win);
            issues_m++;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        repeat (n - 1) @(negedge clk);
        q.delete();
        grants.delete();
        outstanding = 0;
        ptr_m = 0;
        issues_m = 0;
        stalls_m = 0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 60) begin
            drive('0, 1'b1);
            guard++;
        end
        chk("drain_empty", q.size(), 0);
        repeat (4) drive('0, 1'b1);
    endtask

    task automatic single(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_sum);
        logic [NR-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        a_in[idx] = a;
        b_in[idx] = b;
        drive(v, 1'b1);
        chk("single_ready", bus.req_ready, v);
        for (int c = 1; c <= LAT; c++) begin
            drive('0, 1'b1);
            chk("single_early_resp", bus.resp_valid, 1'b0);
        end
        drive('0, 1'b1);
        chk("single_resp_valid", bus.resp_valid, 1'b1);
        chk("single_resp_data", bus.resp_data, exp_sum);
        chk("single_resp_id", bus.resp_id, idx);
    endtask

    // Monitor: pops the scoreboard on every accepted response
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst === 1'b0 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_resp: got id %0d data %0h, required no response",
                         bus.resp_id, bus.resp_data);
            end else begin
                e = q.pop_front();
                outstanding--;
                chk("resp_data", bus.resp_data, e.sum);
                chk("resp_id", bus.resp_id, e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int exp_g [10];
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        do_reset(3);

        drive('0, 1'b0);
        chk("reset_resp_valid", bus.resp_valid, 1'b0);
        chk("reset_resp_data", bus.resp_data, '0);
        chk("reset_resp_id", bus.resp_id, '0);

        single(2, 32'd5, 32'd7, 32'd12);
        single(0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single(0, 32'h8000_0000, 32'h8000_0000, 32'd0);
        drain();

        // Full contention, then requester 1 drops out
        do_reset(2);
        rand_ops();
        repeat (6) drive(4'b1111, 1'b1);
        repeat (4) drive(4'b1101, 1'b1);
        chk("contention_grant_count", grants.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < grants.size()) chk("contention_grant", grants[i], exp_g[i]);
        end
        drain();

        // Reset while two ops are in flight
        do_reset(2);
        a_in[0] = 32'd100; b_in[0] = 32'd1;
        a_in[1] = 32'd200; b_in[1] = 32'd2;
        drive(4'b0001, 1'b1);
        drive(4'b0010, 1'b1);
        do_reset(1);
        repeat (6) begin
            drive('0, 1'b1);
            chk("flushed_no_resp", bus.resp_valid, 1'b0);
        end

        // Backpressure straight after that reset: credits must be fully restored
        rand_ops();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(4'b1111, 1'b0);
            if (i == 0) chk("first_grant_after_reset", bus.req_ready, 4'b0001);
            cnt += int'(bus.pipe_valid);
        end
        chk("bp_issue_count", cnt, 4);
        chk("bp_ready_zero", bus.req_ready, 4'b0000);
        chk("bp_fifo_nonempty", bus.resp_valid, 1'b1);
        drive(4'b1111, 1'b1);
        chk("bp_no_issue_on_pop_cycle", bus.pipe_valid, 1'b0);
`ifdef ADD_PIPE_ARB_STATS_EN
        chk("stats_issue_10cyc", last_ic, 32'd4);
        chk("stats_stall_10cyc", last_sc, 32'd6);
`endif
        drive(4'b1111, 1'b0);
        chk("bp_issue_after_pop", bus.pipe_valid, 1'b1);
        drive(4'b1111, 1'b0);
        chk("bp_single_refill", bus.pipe_valid, 1'b0);
        drain();

        // Randomized traffic
        do_reset(2);
        repeat (400) begin
            rand_ops();
            if ($urandom_range(0, 7) == 0) begin
                a_in[$urandom_range(0, NR-1)] = 32'hFFFF_FFFF;
            end
            drive(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
